// File: rtl/lpm_abs_pkg.sv
// Shared definitions for the lpm_abs_stream slice.
//   - saturate mode encodings
//   - most-negative / max-positive constants for a given lane width
//   - lane slice index helpers for the flattened multi-lane buses
package lpm_abs_pkg;

  localparam int LPM_ABS_WRAP = 0;
  localparam int LPM_ABS_SAT  = 1;

  localparam int LPM_ABS_MAXW = 64;

  // 1 followed by (width-1) zeros; callers cast down to their lane width.
  function automatic logic [LPM_ABS_MAXW-1:0] most_neg(input int width);
    return LPM_ABS_MAXW'(1) << (width - 1);
  endfunction

  // 0 followed by (width-1) ones.
  function automatic logic [LPM_ABS_MAXW-1:0] max_pos(input int width);
    return most_neg(width) - LPM_ABS_MAXW'(1);
  endfunction

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic int lane_hi(input int lane, input int width);
    return lane * width + width - 1;
  endfunction

endpackage

// File: rtl/lpm_abs_stream_if.sv
// Stream bundle for lpm_abs_stream.
//   data/in_valid/in_ready      : producer side
//   result/overflow/out_valid/out_ready : consumer side
//   cnt_clr/ovf_count           : overflow event counter control/status
// slave  = the abs unit's view, master = the environment driving it.
interface lpm_abs_stream_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 1,
  parameter int CNTWIDTH = 16
);
  logic [WIDTH*CHANNELS-1:0] data;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH*CHANNELS-1:0] result;
  logic [CHANNELS-1:0]       overflow;
  logic                      out_valid;
  logic                      out_ready;
  logic                      cnt_clr;
  logic [CNTWIDTH-1:0]       ovf_count;

  modport slave (
    input  data, in_valid, out_ready, cnt_clr,
    output in_ready, result, overflow, out_valid, ovf_count
  );

  modport master (
    output data, in_valid, out_ready, cnt_clr,
    input  in_ready, result, overflow, out_valid, ovf_count
  );
endinterface

// File: rtl/lpm_abs_lane.sv
// Combinational absolute value of one signed lane.
//   data     : signed two's complement input
//   result   : unsigned magnitude, same width (no growth)
//   overflow : input was the most-negative value
// In wrap mode the most-negative input maps to itself; in saturate mode it
// clamps to the largest positive value.
module lpm_abs_lane
  import lpm_abs_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = LPM_ABS_WRAP
) (
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));
  localparam logic [WIDTH-1:0] MAX_POS  = WIDTH'(max_pos(WIDTH));

  always_comb begin
    overflow = (data == MOST_NEG);
    if (!data[WIDTH-1]) begin
      result = data;
    end else if (overflow && (SATURATE == LPM_ABS_SAT)) begin
      result = MAX_POS;
    end else begin
      // For MOST_NEG this negation wraps back to MOST_NEG.
      result = ~data + WIDTH'(1);
    end
  end

endmodule

// File: rtl/lpm_abs_stream.sv
// Pipelined multi-lane absolute value with valid/ready streaming.
//   clock : rising-edge clock
//   sclr  : synchronous active-high clear of all pipeline state and counter
//   io    : lpm_abs_stream_if.slave (data in, result/overflow out,
//           in/out handshakes, cnt_clr, ovf_count)
// Lane math sits in front of stage 1; later stages are plain delay. All
// stages advance together when the last stage is empty or being consumed,
// so in_ready is combinational from out_ready and the last valid bit only.
module lpm_abs_stream
  import lpm_abs_pkg::*;
#(
  parameter string lpm_type     = "lpm_abs_stream",
  parameter int    lpm_width    = 8,
  parameter int    lpm_channels = 1,
  parameter int    lpm_pipeline = 1,
  parameter int    lpm_saturate = LPM_ABS_WRAP,
  parameter int    lpm_cntwidth = 16,
  parameter string lpm_hint     = "UNUSED"
) (
  input  logic             clock,
  input  logic             sclr,
  lpm_abs_stream_if.slave  io
);

  localparam int DW   = lpm_width * lpm_channels;
  localparam int LAST = lpm_pipeline - 1;

  if (lpm_width < 2 || lpm_channels < 1 || lpm_pipeline < 1 || lpm_pipeline > 8 ||
      lpm_cntwidth < 1 || lpm_type != "lpm_abs_stream" || lpm_hint == "") begin : g_param_check
    $error("lpm_abs_stream: unsupported parameter set");
  end

  logic [DW-1:0]           lane_res;
  logic [lpm_channels-1:0] lane_ovf;

  for (genvar k = 0; k < lpm_channels; k++) begin : g_lane
    lpm_abs_lane #(
      .WIDTH    (lpm_width),
      .SATURATE (lpm_saturate)
    ) u_lane (
      .data     (io.data[lane_lo(k, lpm_width) +: lpm_width]),
      .result   (lane_res[lane_lo(k, lpm_width) +: lpm_width]),
      .overflow (lane_ovf[k])
    );
  end

  logic [lpm_pipeline-1:0] vld;
  logic [DW-1:0]           res_q [lpm_pipeline];
  logic [lpm_channels-1:0] ovf_q [lpm_pipeline];
  logic [lpm_cntwidth-1:0] ovf_cnt;
  logic                    advance;
  logic                    out_fire;

  assign advance  = io.out_ready || !vld[LAST];
  assign out_fire = vld[LAST] && io.out_ready;

  always_ff @(posedge clock) begin
    if (sclr) begin
      vld <= '0;
      for (int i = 0; i < lpm_pipeline; i++) begin
        res_q[i] <= '0;
        ovf_q[i] <= '0;
      end
    end else if (advance) begin
      vld[0]   <= io.in_valid;
      res_q[0] <= lane_res;
      ovf_q[0] <= lane_ovf;
      for (int i = 1; i < lpm_pipeline; i++) begin
        vld[i]   <= vld[i-1];
        res_q[i] <= res_q[i-1];
        ovf_q[i] <= ovf_q[i-1];
      end
    end
  end

  // Counts output transfers carrying any overflow lane; sticks at all-ones.
  always_ff @(posedge clock) begin
    if (sclr || io.cnt_clr) begin
      ovf_cnt <= '0;
    end else if (out_fire && (|ovf_q[LAST]) && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + lpm_cntwidth'(1);
    end
  end

  assign io.in_ready  = advance;
  assign io.out_valid = vld[LAST];
  assign io.result    = res_q[LAST];
  assign io.overflow  = ovf_q[LAST];
  assign io.ovf_count = ovf_cnt;

endmodule

// File: tb/tb_lpm_abs_stream.sv
// Two instances share one stimulus stream: a wrap-mode unit with a 4-bit
// counter and a saturate-mode unit with a 2-bit counter. Expected items are
// queued at input transfer and checked by an independent monitor.
module tb_lpm_abs_stream;
  localparam int W  = 8;
  localparam int CH = 2;
  localparam int P  = 3;
  localparam int DW = W * CH;
  localparam int CMAX_W = 15;
  localparam int CMAX_S = 3;

  logic          clock = 1'b0;
  logic          sclr = 1'b1;
  logic [DW-1:0] data = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          cnt_clr = 1'b0;

  lpm_abs_stream_if #(.WIDTH(W), .CHANNELS(CH), .CNTWIDTH(4)) if_w ();
  lpm_abs_stream_if #(.WIDTH(W), .CHANNELS(CH), .CNTWIDTH(2)) if_s ();

  assign if_w.data = data;
  assign if_w.in_valid = in_valid;
  assign if_w.out_ready = out_ready;
  assign if_w.cnt_clr = cnt_clr;
  assign if_s.data = data;
  assign if_s.in_valid = in_valid;
  assign if_s.out_ready = out_ready;
  assign if_s.cnt_clr = cnt_clr;

  lpm_abs_stream #(.lpm_width(W), .lpm_channels(CH), .lpm_pipeline(P),
                   .lpm_saturate(0), .lpm_cntwidth(4)) dut_w (
    .clock(clock), .sclr(sclr), .io(if_w));

  lpm_abs_stream #(.lpm_width(W), .lpm_channels(CH), .lpm_pipeline(P),
                   .lpm_saturate(1), .lpm_cntwidth(2)) dut_s (
    .clock(clock), .sclr(sclr), .io(if_s));

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] res_w;
    logic [DW-1:0] res_s;
    logic [CH-1:0] ovf;
    int            in_cyc;
    bit            stalled;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   cnt_w = 0;
  int   cnt_s = 0;
  int   or_mode = 0;
  int   ph = 0;
  bit   prev_sclr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Signed magnitude by plain integer arithmetic.
  function automatic logic [W-1:0] ref_lane(input logic [W-1:0] x, input bit sat, output bit ovf);
    int v;
    int mag;
    v = int'(x);
    if (v >= 2 ** (W - 1)) v = v - 2 ** W;
    mag = (v < 0) ? -v : v;
    ovf = (mag == 2 ** (W - 1));
    if (ovf && sat) mag = 2 ** (W - 1) - 1;
    return W'(mag);
  endfunction

  function automatic exp_t model(input logic [DW-1:0] d);
    exp_t e;
    bit o;
    for (int k = 0; k < CH; k++) begin
      e.res_w[k*W +: W] = ref_lane(d[k*W +: W], 1'b0, o);
      e.ovf[k] = o;
      e.res_s[k*W +: W] = ref_lane(d[k*W +: W], 1'b1, o);
    end
    e.in_cyc = 0;
    e.stalled = 1'b0;
    return e;
  endfunction

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clock) begin
    cyc++;
    check("ovf_count_w", if_w.ovf_count, cnt_w);
    check("ovf_count_s", if_s.ovf_count, cnt_s);
    check("in_ready_w", if_w.in_ready, out_ready || !if_w.out_valid);
    check("in_ready_s", if_s.in_ready, out_ready || !if_s.out_valid);
    check("out_valid_s", if_s.out_valid, if_w.out_valid);
    if (prev_sclr) begin
      check("rst_out_valid", if_w.out_valid, 0);
      check("rst_result_w", if_w.result, 0);
      check("rst_result_s", if_s.result, 0);
      check("rst_overflow", if_w.overflow, 0);
    end
    if (if_w.out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out", if_w.out_valid, 0);
      end else begin
        check("result_w", if_w.result, sb[0].res_w);
        check("result_s", if_s.result, sb[0].res_s);
        check("overflow_w", if_w.overflow, sb[0].ovf);
        check("overflow_s", if_s.overflow, sb[0].ovf);
      end
    end
    if (!out_ready) foreach (sb[i]) sb[i].stalled = 1'b1;
    if (sclr) begin
      sb.delete();
      cnt_w = 0;
      cnt_s = 0;
    end else begin
      if (if_w.out_valid && out_ready && sb.size() > 0) begin
        mon_e = sb.pop_front();
        if (!mon_e.stalled) check("latency", cyc - mon_e.in_cyc, P);
        if (|mon_e.ovf) begin
          cnt_w = (cnt_w < CMAX_W) ? cnt_w + 1 : CMAX_W;
          cnt_s = (cnt_s < CMAX_S) ? cnt_s + 1 : CMAX_S;
        end
      end
      if (cnt_clr) begin
        cnt_w = 0;
        cnt_s = 0;
      end
      if (in_valid && if_w.in_ready) begin
        mon_e = model(data);
        mon_e.in_cyc = cyc;
        sb.push_back(mon_e);
      end
    end
    prev_sclr = sclr;
  end

  // Consumer: 0 always ready, 1 = 5 low / 3 high, 2 random, 3 blocked.
  initial forever begin
    @(posedge clock);
    #1;
    ph++;
    case (or_mode)
      0: out_ready = 1'b1;
      1: out_ready = (ph % 8) >= 5;
      2: out_ready = ($urandom % 3) != 0;
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send(input logic [DW-1:0] d, input bit clr);
    int budget = 0;
    bit fired = 1'b0;
    data = d;
    in_valid = 1'b1;
    cnt_clr = clr;
    while (!fired) begin
      @(negedge clock);
      fired = if_w.in_ready;
      @(posedge clock);
      #1;
      cnt_clr = 1'b0;
      budget++;
      if (!fired && budget > 200) begin
        check("send_timeout", fired, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    int budget = 0;
    or_mode = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && budget < 300) begin
      @(posedge clock);
      #1;
      budget++;
    end
    check("drain_empty", sb.size(), 0);
    idle(2);
  endtask

  function automatic logic [W-1:0] rand_lane();
    logic [W-1:0] v;
    v = W'($urandom);
    if ($urandom % 4 == 0) v = W'(2 ** (W - 1));
    return v;
  endfunction

  initial begin
    // reset held two edges with live input
    sclr = 1'b1;
    in_valid = 1'b1;
    data = DW'($urandom);
    @(posedge clock);
    #1 data = DW'($urandom);
    @(posedge clock);
    #1;
    sclr = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    check("in_ready_after_reset", if_w.in_ready, 1);
    @(posedge clock);
    #1;

    // wrap / saturate arithmetic
    or_mode = 0;
    idle(1);
    send({8'h80, 8'hFB}, 1'b0);
    send({8'h7F, 8'h00}, 1'b0);
    send({8'h00, 8'h7F}, 1'b0);
    send({8'h81, 8'h80}, 1'b0);
    send({8'hFF, 8'h01}, 1'b0);
    drain();

    // counter saturation, then clear colliding with an overflow transfer
    for (int i = 0; i < 5; i++) send({8'h80, 8'(i)}, 1'b0);
    drain();
    send({8'h80, 8'h01}, 1'b0);
    send({8'h80, 8'h02}, 1'b0);
    send({8'h80, 8'h03}, 1'b0);
    send({8'h80, 8'h04}, 1'b1);
    drain();

    // backpressure with sequential values
    or_mode = 1;
    for (int i = 0; i < 20; i++) send({8'(8'hFF - i), 8'(i)}, 1'b0);
    drain();

    // random traffic
    or_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 4 == 0) idle($urandom_range(1, 3));
      send({rand_lane(), rand_lane()}, ($urandom % 30) == 0);
    end
    drain();

    // mid-stream reset with a full pipeline
    or_mode = 3;
    idle(2);
    send({8'h80, 8'h11}, 1'b0);
    send({8'h90, 8'h22}, 1'b0);
    send({8'hA0, 8'h33}, 1'b0);
    sclr = 1'b1;
    @(posedge clock);
    #1 sclr = 1'b0;
    @(negedge clock);
    check("out_valid_after_sclr", if_w.out_valid, 0);
    or_mode = 0;
    idle(4);
    send({8'hC8, 8'h80}, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
